mux2_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one 8-bit 2:1 byte path between two valid-qualified input lanes in the PHY TX chain.
- Buffers each lane in a small FIFO and picks one lane per clk_4f cycle.
- Drives a registered byte, valid and lane-select out to the serializer stage.
- Replaces free-running select logic with fair, lossless-until-full interleaving.

---
 rtl/mux2_rr_scheduler.sv | 165 ++++++++++++++++
 tb/tb_mux2_rr_scheduler.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mux2_rr_scheduler.sv
// mux2_rr_scheduler: two-lane round-robin byte scheduler for the PHY TX chain.
// Each input lane is buffered in a DEPTH-entry FIFO. Every clk_4f cycle at
// most one lane is popped onto a shared registered byte path. When both lanes
// hold data, the lane that was not popped last wins.
//
// Optional build macro: MUX2_RR_IDLE_PATTERN_EN
//   defined   : Salida shows IDLE_BYTE on every cycle without a pop and at reset
//   undefined : Salida holds the last popped byte (0 after reset)
//
// Ports:
//   clk_4f                  single clock, rising edge
//   reset                   asynchronous active-low reset
//   Entrada0/validEntrada0  lane 0 byte and valid
//   Entrada1/validEntrada1  lane 1 byte and valid
//   stall                   downstream not ready; no pop this cycle
//   Salida                  registered output byte
//   validsalida             registered; Salida carries a byte popped at the last edge
//   sel                     registered; lane that produced Salida
//   full0/full1             FIFO holds DEPTH entries (combinational from count)
//   overflow0/overflow1     sticky; a byte of that lane was dropped
module mux2_rr_scheduler #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [7:0]  IDLE_BYTE = 8'hBC
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [7:0] Entrada0,
  input  logic       validEntrada0,
  input  logic [7:0] Entrada1,
  input  logic       validEntrada1,
  input  logic       stall,
  output logic [7:0] Salida,
  output logic       validsalida,
  output logic       sel,
  output logic       full0,
  output logic       full1,
  output logic       overflow0,
  output logic       overflow1
);

  localparam int unsigned DW = 8;
  localparam int unsigned NL = 2;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

`ifdef MUX2_RR_IDLE_PATTERN_EN
  localparam logic [DW-1:0] SALIDA_RST = IDLE_BYTE;
`else
  localparam logic [DW-1:0] SALIDA_RST = '0;
  // IDLE_BYTE only matters in the idle-pattern build.
  logic [DW-1:0] idle_byte_unused;
  assign idle_byte_unused = IDLE_BYTE;
`endif

  logic [DW-1:0] mem  [NL][DEPTH];
  logic [AW-1:0] rptr [NL];
  logic [AW-1:0] wptr [NL];
  logic [CW-1:0] cnt  [NL];

  // Round-robin pointer: lane popped most recently.
  logic last;

  logic [NL-1:0]         vin_c;
  logic [NL-1:0][DW-1:0] din_c;
  logic [NL-1:0]         full_c;
  logic [NL-1:0]         nempty_c;
  logic [NL-1:0]         pop_c;
  logic [NL-1:0]         push_c;
  logic [NL-1:0]         drop_c;
  logic                  pop_any_c;
  logic                  pop_lane_c;
  logic [DW-1:0]         head_c;

  assign vin_c = {validEntrada1, validEntrada0};
  assign din_c = {Entrada1, Entrada0};

  // Arbitration on pre-edge FIFO state; push accepted when a same-cycle pop frees a slot.
  always_comb begin
    full_c     = '0;
    nempty_c   = '0;
    pop_c      = '0;
    push_c     = '0;
    drop_c     = '0;
    pop_any_c  = 1'b0;
    pop_lane_c = 1'b0;
    for (int i = 0; i < NL; i++) begin
      full_c[i]   = (cnt[i] == CW'(DEPTH));
      nempty_c[i] = (cnt[i] != '0);
    end
    pop_any_c  = !stall && (|nempty_c);
    pop_lane_c = (&nempty_c) ? ~last : nempty_c[1];
    if (pop_any_c) begin
      pop_c[pop_lane_c] = 1'b1;
    end
    for (int i = 0; i < NL; i++) begin
      push_c[i] = vin_c[i] && (!full_c[i] || pop_c[i]);
      drop_c[i] = vin_c[i] && full_c[i] && !pop_c[i];
    end
    head_c = mem[pop_lane_c][rptr[pop_lane_c]];
  end

  assign full0 = full_c[0];
  assign full1 = full_c[1];

  // FIFO storage; contents are don't-care while the lane is empty.
  always_ff @(posedge clk_4f) begin
    for (int i = 0; i < NL; i++) begin
      if (push_c[i]) begin
        mem[i][wptr[i]] <= din_c[i];
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NL; i++) begin
        rptr[i] <= '0;
        wptr[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (push_c[i]) begin
          wptr[i] <= wptr[i] + AW'(1);
        end
        if (pop_c[i]) begin
          rptr[i] <= rptr[i] + AW'(1);
        end
        case ({push_c[i], pop_c[i]})
          2'b10:   cnt[i] <= cnt[i] + CW'(1);
          2'b01:   cnt[i] <= cnt[i] - CW'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // Output byte path, round-robin pointer and sticky overflow flags.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      Salida      <= SALIDA_RST;
      validsalida <= 1'b0;
      sel         <= 1'b0;
      last        <= 1'b1;
      overflow0   <= 1'b0;
      overflow1   <= 1'b0;
    end else begin
      overflow0 <= overflow0 | drop_c[0];
      overflow1 <= overflow1 | drop_c[1];
      if (pop_any_c) begin
        Salida      <= head_c;
        sel         <= pop_lane_c;
        validsalida <= 1'b1;
        last        <= pop_lane_c;
      end else begin
        validsalida <= 1'b0;
`ifdef MUX2_RR_IDLE_PATTERN_EN
        Salida      <= IDLE_BYTE;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mux2_rr_scheduler.sv
// Scoreboard bench for mux2_rr_scheduler: a queue-based lane model predicts
// each popped byte; a monitor checks the DUT output stream against it.
module tb_mux2_rr_scheduler;

  localparam int unsigned DEPTH = 4;
`ifdef MUX2_RR_IDLE_PATTERN_EN
  localparam logic [7:0] RST_BYTE = 8'hBC;
  localparam bit         IDLE_PAT = 1'b1;
`else
  localparam logic [7:0] RST_BYTE = 8'h00;
  localparam bit         IDLE_PAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] e0 = '0, e1 = '0;
  logic       v0 = 1'b0, v1 = 1'b0, st = 1'b0;
  logic [7:0] salida;
  logic       vsal, sel, f0, f1, ov0, ov1;

  mux2_rr_scheduler #(.DEPTH(DEPTH), .IDLE_BYTE(8'hBC)) dut (
    .clk_4f(clk), .reset(rst_n),
    .Entrada0(e0), .validEntrada0(v0),
    .Entrada1(e1), .validEntrada1(v1),
    .stall(st),
    .Salida(salida), .validsalida(vsal), .sel(sel),
    .full0(f0), .full1(f1), .overflow0(ov0), .overflow1(ov1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-lane byte queues plus the round-robin rule.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [8:0] exp_q[$];
  bit         m_last;
  bit         m_ov0, m_ov1, m_valid;
  logic [7:0] m_byte;
  bit         m_sel;
  bit         chk_en = 1'b0;

  task automatic model_clear();
    q0.delete(); q1.delete(); exp_q.delete();
    m_last = 1'b1; m_ov0 = 1'b0; m_ov1 = 1'b0; m_valid = 1'b0;
    m_byte = RST_BYTE; m_sel = 1'b0;
  endtask

  task automatic model_step();
    int lane = -1;
    if (!st) begin
      if (q0.size() > 0 && q1.size() > 0) lane = m_last ? 0 : 1;
      else if (q0.size() > 0)             lane = 0;
      else if (q1.size() > 0)             lane = 1;
    end
    if (lane >= 0) begin
      m_byte  = (lane == 0) ? q0.pop_front() : q1.pop_front();
      m_sel   = (lane == 1);
      m_last  = (lane == 1);
      m_valid = 1'b1;
      exp_q.push_back({m_sel, m_byte});
    end else begin
      m_valid = 1'b0;
      if (IDLE_PAT) m_byte = 8'hBC;
    end
    // After a same-cycle pop a full lane has room again.
    if (v0) begin
      if (q0.size() < DEPTH) q0.push_back(e0); else m_ov0 = 1'b1;
    end
    if (v1) begin
      if (q1.size() < DEPTH) q1.push_back(e1); else m_ov1 = 1'b1;
    end
  endtask

  task automatic cycle(input logic a_v0, input logic [7:0] a_d0,
                       input logic a_v1, input logic [7:0] a_d1, input logic a_st);
    @(negedge clk);
    v0 = a_v0; e0 = a_d0; v1 = a_v1; e1 = a_d1; st = a_st;
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  // Reset asserted asynchronously between edges; outputs checked before any edge.
  task automatic do_reset();
    @(negedge clk);
    chk_en = 1'b0;
    v0 = 1'b0; v1 = 1'b0; st = 1'b0; e0 = '0; e1 = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_salida", 32'(salida), 32'(RST_BYTE));
    chk("rst_valid", 32'(vsal), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_full", 32'({f1, f0}), 32'd0);
    chk("rst_ovf", 32'({ov1, ov0}), 32'd0);
    model_clear();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a byte.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("valid", 32'(vsal), 32'(m_valid));
      if (vsal) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_out: got sel=%0d byte=%0h expected none at %0t", sel, salida, $time);
        end else begin
          chk("out_sel_byte", 32'({sel, salida}), 32'(exp_q.pop_front()));
        end
      end else begin
        chk("idle_salida", 32'(salida), 32'(m_byte));
        chk("idle_sel", 32'(sel), 32'(m_sel));
      end
      chk("full0", 32'(f0), 32'(q0.size() == DEPTH));
      chk("full1", 32'(f1), 32'(q1.size() == DEPTH));
      chk("overflow0", 32'(ov0), 32'(m_ov0));
      chk("overflow1", 32'(ov1), 32'(m_ov1));
    end
  end

  initial begin
    model_clear();
    do_reset();

    // Lane 0 only, three consecutive bytes.
    cycle(1'b1, 8'h11, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 8'h00, 1'b0);
    idle(4);

    // Both lanes every cycle from reset: expect A0,B0,A1,B1,A2,B2.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b1, 8'hB0 + 8'(i), 1'b0);
    idle(7);

    // Lane 1 overflow under stall, then drain.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 8'h50 + 8'(i), 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    idle(6);

    // Lane 0 full with same-cycle push and pop across the pointer wrap.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b0, 8'h00, 1'b1);
    for (int i = 4; i < 12; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b0, 8'h00, 1'b0);
    idle(6);

    // Mid-stream reset with both FIFOs half full.
    cycle(1'b1, 8'h71, 1'b1, 8'h81, 1'b1);
    cycle(1'b1, 8'h72, 1'b1, 8'h82, 1'b1);
    cycle(1'b1, 8'h73, 1'b1, 8'h83, 1'b0);
    do_reset();
    idle(5);

    // Randomized traffic with stall bursts.
    for (int i = 0; i < 3000; i++) begin
      logic rv0, rv1, rst_b;
      rv0   = ($urandom_range(0, 99) < 60);
      rv1   = ($urandom_range(0, 99) < 55);
      rst_b = ((i / 64) % 3 == 1) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 15);
      cycle(rv0, 8'($urandom), rv1, 8'($urandom), rst_b);
      if (i == 1500) do_reset();
    end
    idle(2 * DEPTH + 4);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
